ps2_kbd_rx: RTL and testbench

PS/2 keyboard receiver that deserialises device-to-host frames from the raw PS/2 clock/data pins. It produces the byte/strobe/error triple consumed by the SoC keyboard inputs (ps2_kbd_code_i, ps2_kbd_strobe_i, ps2_kbd_err_i). It sits directly upstream of the SoC at board top level, in the system clock domain. It provides pin synchronisation, glitch filtering, frame checking and a stall watchdog.

---
 rtl/ps2_kbd_rx.sv | 162 ++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// -----------------------------------------------------------------------------
// ps2_kbd_rx
//   Receives device-to-host PS/2 keyboard frames from the raw pins and turns
//   them into a byte plus one-cycle strobe/error pulses in the system clock
//   domain. Both pins are synchronised, the PS/2 clock is glitch-filtered and
//   a watchdog aborts frames whose clock stops mid-frame.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset_i     synchronous active-high reset
//   ps2_clk_i   raw PS/2 clock pin (asynchronous)
//   ps2_data_i  raw PS/2 data pin (asynchronous)
//   code_o      last received byte, held until the next completed frame
//   strobe_o    one-cycle pulse: a complete frame was received
//   err_o       one-cycle pulse: bad start/parity/stop, or watchdog timeout
//   busy_o      high while a frame is in progress
// -----------------------------------------------------------------------------
module ps2_kbd_rx #(
    parameter int FREQ_HZ    = 2000000,
    parameter int TIMEOUT_US = 1000,
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] code_o,
    output logic       strobe_o,
    output logic       err_o,
    output logic       busy_o
);

    localparam int LIMIT  = FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int TCNT_W = $clog2(LIMIT + 1);
    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(LIMIT - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t              state_q, state_n;
    logic [1:0]          clk_sync_q, data_sync_q;
    logic [FCNT_W-1:0]   filt_cnt_q;
    logic                clk_filt_q, clk_filt_d_q;
    logic                sample_q;
    logic [2:0]          bit_cnt_q;
    logic [7:0]          shift_q;
    logic                parity_q;
    logic [TCNT_W-1:0]   tcnt_q;
    logic                data_s;
    logic                timeout;
    logic                strobe_n, err_n, load_n;

    assign data_s = data_sync_q[1];

    // Two-flop synchronisers plus clock glitch filter. The filtered level only
    // flips after FILTER_LEN consecutive synchronised samples disagree with it;
    // any sample agreeing with the current level restarts the count.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            filt_cnt_q   <= '0;
            clk_filt_q   <= 1'b1;
            clk_filt_d_q <= 1'b1;
            sample_q     <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q  <= {data_sync_q[0], ps2_data_i};
            clk_filt_d_q <= clk_filt_q;
            // Registered falling-edge detect of the filtered clock.
            sample_q     <= clk_filt_d_q & ~clk_filt_q;
            if (clk_sync_q[1] == clk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FCNT_LAST) begin
                clk_filt_q <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // The watchdog fires when the gap since the last sample point reaches LIMIT.
    assign timeout = (state_q != IDLE) && !sample_q && (tcnt_q == TCNT_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_n;
    end

    // FSM next-state logic.
    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:   if (sample_q && !data_s)             state_n = DATA;
            DATA:   if (sample_q && bit_cnt_q == 3'd7)   state_n = PARITY;
            PARITY: if (sample_q)                        state_n = STOP;
            STOP:   if (sample_q)                        state_n = IDLE;
            default:                                     state_n = IDLE;
        endcase
        if (timeout) state_n = IDLE;
    end

    // FSM output logic: next values of the registered pulses and the code load.
    always_comb begin
        strobe_n = 1'b0;
        err_n    = 1'b0;
        load_n   = 1'b0;
        unique case (state_q)
            IDLE: if (sample_q && data_s) err_n = 1'b1;
            STOP: if (sample_q) begin
                strobe_n = 1'b1;
                load_n   = 1'b1;
                // Odd parity: data XOR parity must be 1; stop bit must be 1.
                err_n    = ((^shift_q) == parity_q) || !data_s;
            end
            default: ;
        endcase
        if (timeout) err_n = 1'b1;
    end

    assign busy_o = (state_q != IDLE);

    // Datapath: shift register, parity, bit/timeout counters and outputs.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tcnt_q    <= '0;
            code_o    <= '0;
            strobe_o  <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            strobe_o <= strobe_n;
            err_o    <= err_n;
            if (load_n) code_o <= shift_q;

            if (state_q == IDLE || sample_q) tcnt_q <= '0;
            else                             tcnt_q <= tcnt_q + 1'b1;

            if (sample_q) begin
                unique case (state_q)
                    IDLE:   bit_cnt_q <= '0;
                    DATA: begin
                        shift_q[bit_cnt_q] <= data_s;
                        bit_cnt_q          <= bit_cnt_q + 1'b1;
                    end
                    PARITY: parity_q <= data_s;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_kbd_rx
//   Drives PS/2 frames onto the pins at an 80 us bit period (2 MHz system
//   clock), records every strobe/err pulse the receiver emits and compares the
//   record with the events predicted from the frame contents.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    localparam int FREQ_HZ    = 2000000;
    localparam int TIMEOUT_US = 1000;
    localparam int FILTER_LEN = 4;
    localparam int LIMIT      = FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int HALF       = 80;                  // 40 us in clk cycles
    localparam int LAT        = FILTER_LEN + 3;      // pin fall -> sample point

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic [7:0] code_o;
    logic       strobe_o, err_o, busy_o;

    ps2_kbd_rx #(
        .FREQ_HZ   (FREQ_HZ),
        .TIMEOUT_US(TIMEOUT_US),
        .FILTER_LEN(FILTER_LEN)
    ) dut (
        .clk       (clk),
        .reset_i   (reset_i),
        .ps2_clk_i (ps2_clk_i),
        .ps2_data_i(ps2_data_i),
        .code_o    (code_o),
        .strobe_o  (strobe_o),
        .err_o     (err_o),
        .busy_o    (busy_o)
    );

    always #250 clk = ~clk;

    typedef struct {
        logic       s;
        logic       e;
        logic [7:0] code;
        int         cyc;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_code = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse with the cycle it became visible.
    always @(negedge clk) begin
        if (strobe_o || err_o) obs_q.push_back('{strobe_o, err_o, code_o, cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame layout: bit0 start, bits 8:1 data LSB first, bit9 parity, bit10 stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par_ok, input bit stop);
        logic par;
        par = ~(^b);
        if (!par_ok) par = ~par;
        return {stop, par, b, 1'b0};
    endfunction

    // Sends the first nbits of a frame. glitch_bit >= 0 adds a 2-cycle low
    // glitch on the PS/2 clock during the high phase of that bit.
    task automatic send_frame(input logic [10:0] bits, input int nbits,
                              input int glitch_bit, output int last_fall);
        last_fall = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data_i = bits[i];
            if (i == glitch_bit) begin
                repeat (20) @(negedge clk);
                ps2_clk_i = 1'b0;
                repeat (2) @(negedge clk);
                ps2_clk_i = 1'b1;
                repeat (HALF - 22) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk_i = 1'b0;
            last_fall = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk_i = 1'b1;
        end
        @(negedge clk);
        ps2_data_i = 1'b1;
    endtask

    // Reference model: what a (possibly truncated) frame must produce.
    // The first posedge after the pin changes is cycle last_fall+1; the sample
    // point is LAT cycles after that.
    task automatic model_frame(input logic [10:0] bits, input int nbits, input int last_fall);
        int  ones;
        bit  bad;
        if (nbits == 11) begin
            ones = $countones(bits[9:1]);
            bad  = (ones % 2 == 0) || (bits[10] == 1'b0);
            exp_code = bits[8:1];
            exp_q.push_back('{1'b1, bad, bits[8:1], last_fall + 1 + LAT});
        end else if (nbits > 0 && bits[0] == 1'b0) begin
            exp_q.push_back('{1'b0, 1'b1, exp_code, last_fall + 1 + LAT + LIMIT});
        end
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, ".events"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, ".strobe"}, 32'(obs_q[i].s),    32'(exp_q[i].s));
            check({tag, ".err"},    32'(obs_q[i].e),    32'(exp_q[i].e));
            check({tag, ".code"},   32'(obs_q[i].code), 32'(exp_q[i].code));
            check({tag, ".cycle"},  32'(obs_q[i].cyc),  32'(exp_q[i].cyc));
        end
        check({tag, ".code_hold"}, 32'(code_o), 32'(exp_code));
        check({tag, ".busy"},      32'(busy_o), 32'(0));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_frame(input string tag, input logic [10:0] f, input int glitch_bit, input int gap);
        int lf;
        send_frame(f, 11, glitch_bit, lf);
        model_frame(f, 11, lf);
        repeat (gap) @(negedge clk);
        compare_events(tag);
    endtask

    initial begin
        int lf;
        logic [10:0] f;

        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        check("reset.code",   32'(code_o),   32'(0));
        check("reset.strobe", 32'(strobe_o), 32'(0));
        check("reset.err",    32'(err_o),    32'(0));
        check("reset.busy",   32'(busy_o),   32'(0));
        repeat (20) @(negedge clk);

        // Good frame.
        run_frame("good_1c", mk_frame(8'h1C, 1, 1), -1, 200);

        // Back-to-back with 100 us gap; both expectations collected together.
        f = mk_frame(8'hF0, 1, 1);
        send_frame(f, 11, -1, lf);
        model_frame(f, 11, lf);
        repeat (200) @(negedge clk);
        f = mk_frame(8'h1C, 1, 1);
        send_frame(f, 11, -1, lf);
        model_frame(f, 11, lf);
        repeat (200) @(negedge clk);
        compare_events("b2b");

        // Bad parity, then bad stop bit.
        run_frame("bad_par", mk_frame(8'h1C, 0, 1), -1, 200);
        run_frame("bad_stop", mk_frame(8'h5A, 1, 0), -1, 200);

        // Frame aborted after start + 5 data bits; watchdog must fire.
        f = mk_frame(8'hA7, 1, 1);
        send_frame(f, 6, -1, lf);
        model_frame(f, 6, lf);
        repeat (10) @(negedge clk);
        check("abort.busy_mid", 32'(busy_o), 32'(1));
        repeat (LIMIT + 100) @(negedge clk);
        compare_events("abort");

        // Glitch while idle produces nothing; glitch mid-frame is ignored.
        ps2_clk_i = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk_i = 1'b1;
        repeat (50) @(negedge clk);
        compare_events("glitch_idle");
        run_frame("glitch_29", mk_frame(8'h29, 1, 1), 4, 200);

        // Reset mid-frame after 4 data bits.
        f = mk_frame(8'h3C, 1, 1);
        send_frame(f, 5, -1, lf);
        reset_i = 1'b1;
        @(negedge clk);
        check("rst_mid.code",   32'(code_o),   32'(0));
        check("rst_mid.strobe", 32'(strobe_o), 32'(0));
        check("rst_mid.err",    32'(err_o),    32'(0));
        check("rst_mid.busy",   32'(busy_o),   32'(0));
        reset_i  = 1'b0;
        exp_code = 8'h00;
        repeat (LIMIT + 100) @(negedge clk);
        compare_events("rst_mid");
        run_frame("after_rst", mk_frame(8'h1C, 1, 1), -1, 200);

        // Randomised frames, mostly good, some with parity or stop errors.
        for (int i = 0; i < 12; i++) begin
            f = mk_frame(8'($urandom), $urandom_range(3) != 0, $urandom_range(7) != 0);
            run_frame("rand", f, -1, 200 + $urandom_range(400));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
